// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: round-robin VC pick per input, then round-robin input pick per output.
// Grants are registered, so they are valid one edge after sampling; an output whose downstream_ready is low gets no grant.
module switch_allocator #(
  parameter int PORT_NUM  = 5,
  parameter int VC_NUM    = 2,
  parameter int PORT_SIZE = $clog2(PORT_NUM),
  parameter int VC_SIZE   = $clog2(VC_NUM)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]               request,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port,
  input  logic [PORT_NUM-1:0]                           downstream_ready,
  output logic [PORT_NUM-1:0][PORT_SIZE-1:0]            input_vc_sel,
  output logic [PORT_NUM-1:0]                           valid_sel,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]               vc_grant
);

  logic [PORT_NUM-1:0][VC_SIZE-1:0]   r_in_ptr;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] r_out_ptr;
  logic [PORT_NUM-1:0]                r_valid_sel;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] r_input_vc_sel;
  logic [PORT_NUM-1:0][VC_NUM-1:0]    r_vc_grant;

  logic [PORT_NUM-1:0]                w_s1_vld;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   w_s1_vc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] w_s1_port;
  logic [PORT_NUM-1:0]                w_s2_vld;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] w_s2_in;
  logic [PORT_NUM-1:0]                w_in_gnt;
  logic [PORT_NUM-1:0][VC_NUM-1:0]    w_vc_grant;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   w_in_ptr_nxt;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] w_out_ptr_nxt;

  // Stage 1: a blocked VC is simply skipped, so it never hides an eligible sibling.
  always_comb begin
    logic [VC_SIZE:0]   v_sum;
    logic [VC_SIZE-1:0] v_idx;
    logic [PORT_SIZE-1:0] v_tgt;
    v_sum     = '0;
    v_idx     = '0;
    v_tgt     = '0;
    w_s1_vld  = '0;
    w_s1_vc   = '0;
    w_s1_port = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        v_sum = {1'b0, r_in_ptr[p]} + (VC_SIZE+1)'(k);
        if (v_sum >= (VC_SIZE+1)'(VC_NUM)) v_sum = v_sum - (VC_SIZE+1)'(VC_NUM);
        v_idx = v_sum[VC_SIZE-1:0];
        v_tgt = out_port[p][v_idx];
        if (!w_s1_vld[p] && request[p][v_idx] &&
            ({1'b0, v_tgt} < (PORT_SIZE+1)'(PORT_NUM)) && downstream_ready[v_tgt]) begin
          w_s1_vld[p]  = 1'b1;
          w_s1_vc[p]   = v_idx;
          w_s1_port[p] = v_tgt;
        end
      end
    end
  end

  always_comb begin
    logic [PORT_SIZE:0]   v_sum;
    logic [PORT_SIZE-1:0] v_q;
    v_sum    = '0;
    v_q      = '0;
    w_s2_vld = '0;
    w_s2_in  = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        v_sum = {1'b0, r_out_ptr[o]} + (PORT_SIZE+1)'(k);
        if (v_sum >= (PORT_SIZE+1)'(PORT_NUM)) v_sum = v_sum - (PORT_SIZE+1)'(PORT_NUM);
        v_q = v_sum[PORT_SIZE-1:0];
        if (!w_s2_vld[o] && w_s1_vld[v_q] && (w_s1_port[v_q] == PORT_SIZE'(o))) begin
          w_s2_vld[o] = 1'b1;
          w_s2_in[o]  = v_q;
        end
      end
    end
  end

  always_comb begin
    w_in_gnt   = '0;
    w_vc_grant = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (w_s2_vld[o] && (w_s2_in[o] == PORT_SIZE'(p))) begin
          w_in_gnt[p]               = 1'b1;
          w_vc_grant[p][w_s1_vc[p]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [PORT_SIZE:0] v_po;
    logic [VC_SIZE:0]   v_pv;
    v_po          = '0;
    v_pv          = '0;
    w_out_ptr_nxt = '0;
    w_in_ptr_nxt  = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      v_po = {1'b0, w_s2_in[o]} + (PORT_SIZE+1)'(1);
      if (v_po >= (PORT_SIZE+1)'(PORT_NUM)) v_po = v_po - (PORT_SIZE+1)'(PORT_NUM);
      w_out_ptr_nxt[o] = v_po[PORT_SIZE-1:0];
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      v_pv = {1'b0, w_s1_vc[p]} + (VC_SIZE+1)'(1);
      if (v_pv >= (VC_SIZE+1)'(VC_NUM)) v_pv = v_pv - (VC_SIZE+1)'(VC_NUM);
      w_in_ptr_nxt[p] = v_pv[VC_SIZE-1:0];
    end
  end

  // Pointers move only on a final grant; a stage-1 winner that loses stage 2 keeps its VC pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ptr       <= '0;
      r_out_ptr      <= '0;
      r_valid_sel    <= '0;
      r_input_vc_sel <= '0;
      r_vc_grant     <= '0;
    end else begin
      r_valid_sel    <= w_s2_vld;
      r_input_vc_sel <= w_s2_in;
      r_vc_grant     <= w_vc_grant;
      for (int o = 0; o < PORT_NUM; o++) begin
        if (w_s2_vld[o]) r_out_ptr[o] <= w_out_ptr_nxt[o];
      end
      for (int p = 0; p < PORT_NUM; p++) begin
        if (w_in_gnt[p]) r_in_ptr[p] <= w_in_ptr_nxt[p];
      end
    end
  end

  assign valid_sel    = r_valid_sel;
  assign input_vc_sel = r_input_vc_sel;
  assign vc_grant     = r_vc_grant;

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: expected grants queued at drive time, popped after each edge.
module tb_switch_allocator;
  localparam int P  = 5;
  localparam int V  = 2;
  localparam int PS = 3;

  typedef struct packed {
    logic [P-1:0]         vs;
    logic [P-1:0][PS-1:0] sel;
    logic [P-1:0][V-1:0]  gr;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [P-1:0][V-1:0]         request;
  logic [P-1:0][V-1:0][PS-1:0] out_port;
  logic [P-1:0]                downstream_ready;
  logic [P-1:0][PS-1:0]        input_vc_sel;
  logic [P-1:0]                valid_sel;
  logic [P-1:0][V-1:0]         vc_grant;

  exp_t       obs;
  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] flit   [P];
  logic [7:0] data_o [P];

  switch_allocator #(.PORT_NUM(P), .VC_NUM(V)) dut (
    .clk              (clk),
    .rst              (rst),
    .request          (request),
    .out_port         (out_port),
    .downstream_ready (downstream_ready),
    .input_vc_sel     (input_vc_sel),
    .valid_sel        (valid_sel),
    .vc_grant         (vc_grant)
  );

  always #5 clk = ~clk;

  assign obs = {valid_sel, input_vc_sel, vc_grant};

  // Crossbar model driven by the allocator's select vector.
  always_comb begin
    for (int o = 0; o < P; o++) data_o[o] = flit[input_vc_sel[o]];
  end

  function automatic exp_t one(int o, int p, int v);
    exp_t e = '0;
    e.vs[o]    = 1'b1;
    e.sel[o]   = PS'(p);
    e.gr[p][v] = 1'b1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    request          = '0;
    out_port         = '0;
    downstream_ready = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    request[0] = 2'b11; out_port[0][0] = 3'd0; out_port[0][1] = 3'd0;
    request[1][0] = 1'b1; out_port[1][0] = 3'd0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== exp_t'(0)) $display("FAIL reset_async: got %h, expected 0", obs);
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== exp_t'(0)) $display("FAIL reset_held_edge: got %h, expected 0", obs);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(one(0, 0, 0));
    tick();
    e = sb_q.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL reset_first_grant: got vs=%b sel=%h gr=%b, expected vs=%b sel=%h gr=%b",
                            obs.vs, obs.sel, obs.gr, e.vs, e.sel, e.gr);
    else n_pass++;
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    request[2][1] = 1'b1; out_port[2][1] = 3'd4;
    for (int c = 0; c < 2; c++) begin
      sb_q.push_back(one(4, 2, 1));
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL single_c%0d: got vs=%b sel=%h gr=%b, expected vs=%b sel=%h gr=%b",
                              c, obs.vs, obs.sel, obs.gr, e.vs, e.sel, e.gr);
      else n_pass++;
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int   ins[4] = '{0, 1, 3, 0};
    do_reset();
    request[0][0] = 1'b1; out_port[0][0] = 3'd2;
    request[1][0] = 1'b1; out_port[1][0] = 3'd2;
    request[3][0] = 1'b1; out_port[3][0] = 3'd2;
    for (int c = 0; c < 4; c++) begin
      sb_q.push_back(one(2, ins[c], 0));
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL contention_c%0d: got vs=%b sel=%h gr=%b, expected vs=%b sel=%h gr=%b",
                              c, obs.vs, obs.sel, obs.gr, e.vs, e.sel, e.gr);
      else n_pass++;
      n_checks++;
      if ($countones(vc_grant) !== 1) $display("FAIL contention_onegrant_c%0d: got %0d grants, expected 1",
                                               c, $countones(vc_grant));
      else n_pass++;
    end
  endtask

  task automatic test_vc_rr();
    exp_t e;
    int   outs[3] = '{0, 3, 0};
    int   vcs[3]  = '{0, 1, 0};
    do_reset();
    request[1] = 2'b11; out_port[1][0] = 3'd0; out_port[1][1] = 3'd3;
    for (int c = 0; c < 3; c++) begin
      sb_q.push_back(one(outs[c], 1, vcs[c]));
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL vc_rr_c%0d: got vs=%b sel=%h gr=%b, expected vs=%b sel=%h gr=%b",
                              c, obs.vs, obs.sel, obs.gr, e.vs, e.sel, e.gr);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_reset();
    downstream_ready[3] = 1'b0;
    request[4] = 2'b11; out_port[4][0] = 3'd3; out_port[4][1] = 3'd1;
    sb_q.push_back(one(1, 4, 1));
    tick();
    e = sb_q.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL bp_blocked: got vs=%b sel=%h gr=%b, expected vs=%b sel=%h gr=%b",
                            obs.vs, obs.sel, obs.gr, e.vs, e.sel, e.gr);
    else n_pass++;
    n_checks++;
    if (valid_sel[3] !== 1'b0) $display("FAIL bp_out3_idle: got %b, expected 0", valid_sel[3]);
    else n_pass++;
    @(negedge clk);
    downstream_ready[3] = 1'b1;
    sb_q.push_back(one(3, 4, 0));
    tick();
    e = sb_q.pop_front();
    n_checks++;
    if (obs !== e) $display("FAIL bp_released: got vs=%b sel=%h gr=%b, expected vs=%b sel=%h gr=%b",
                            obs.vs, obs.sel, obs.gr, e.vs, e.sel, e.gr);
    else n_pass++;
  endtask

  task automatic test_permutation();
    exp_t e;
    do_reset();
    for (int k = 0; k < P; k++) begin
      @(negedge clk);
      e = '0;
      for (int i = 0; i < P; i++) begin
        request[i][0]  = 1'b1;
        out_port[i][0] = PS'((i + k) % P);
        e.gr[i][0]     = 1'b1;
        e.sel[i]       = PS'((i - k + P) % P);
      end
      e.vs = '1;
      sb_q.push_back(e);
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) $display("FAIL perm_k%0d: got vs=%b sel=%h gr=%b, expected vs=%b sel=%h gr=%b",
                              k, obs.vs, obs.sel, obs.gr, e.vs, e.sel, e.gr);
      else n_pass++;
      for (int o = 0; o < P; o++) begin
        n_checks++;
        if (data_o[o] !== flit[(o - k + P) % P])
          $display("FAIL perm_data_k%0d_o%0d: got %h, expected %h", k, o, data_o[o], flit[(o - k + P) % P]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < P; i++) flit[i] = 8'hA0 + 8'(i);
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_vc_rr();
    test_backpressure();
    test_permutation();
    n_checks++;
    if (sb_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
